alu_rs: RTL and testbench



---
 rtl/alu_rs.sv | 210 +++++++++++++++++++++
 tb/tb_alu_rs.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rs.sv
// Reservation station ahead of the integer ALU: holds dispatched ops until both operands
// are available, snoops the CDB for wakeup, and issues the lowest-index ready entry each cycle.
module alu_rs #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned TAG_WIDTH  = 4
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    flush,
  input  logic                    disp_valid,
  output logic                    disp_ready,
  input  logic [6:0]              disp_opcode,
  input  logic [5:0]              disp_funct3,
  input  logic [6:0]              disp_funct7,
  input  logic [4:0]              disp_imm5,
  input  logic [6:0]              disp_imm_funct,
  input  logic [TAG_WIDTH-1:0]    disp_dest_tag,
  input  logic                    disp_src1_rdy,
  input  logic                    disp_src2_rdy,
  input  logic [DATA_WIDTH-1:0]   disp_src1_val,
  input  logic [DATA_WIDTH-1:0]   disp_src2_val,
  input  logic [TAG_WIDTH-1:0]    disp_src1_tag,
  input  logic [TAG_WIDTH-1:0]    disp_src2_tag,
  input  logic                    cdb_valid,
  input  logic [TAG_WIDTH-1:0]    cdb_tag,
  input  logic [DATA_WIDTH-1:0]   cdb_data,
  output logic [6:0]              opcode,
  output logic [5:0]              funct3,
  output logic [6:0]              funct7,
  output logic [4:0]              reduced_Imm,
  output logic [6:0]              Imm_funct,
  output logic [DATA_WIDTH-1:0]   BusWires1,
  output logic [DATA_WIDTH-1:0]   BusWires2,
  output logic                    data_out_valid,
  output logic [TAG_WIDTH-1:0]    issue_tag,
  output logic [$clog2(DEPTH):0]  occupancy
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned OccW = IdxW + 1;

  typedef struct packed {
    logic [6:0]            opcode;
    logic [5:0]            funct3;
    logic [6:0]            funct7;
    logic [4:0]            imm5;
    logic [6:0]            imm_funct;
    logic [TAG_WIDTH-1:0]  dest_tag;
    logic                  src1_rdy;
    logic [DATA_WIDTH-1:0] src1_val;
    logic [TAG_WIDTH-1:0]  src1_tag;
    logic                  src2_rdy;
    logic [DATA_WIDTH-1:0] src2_val;
    logic [TAG_WIDTH-1:0]  src2_tag;
  } entry_t;

  entry_t             ent_q [DEPTH];
  entry_t             ent_d [DEPTH];
  entry_t             new_ent;
  logic [DEPTH-1:0]   valid_q, valid_d;
  logic [OccW-1:0]    occ_q, occ_d;

  logic               free_found, sel_found, disp_fire;
  logic [IdxW-1:0]    free_idx, sel_idx;
  logic               cdb_hit1, cdb_hit2;

  logic [6:0]            opcode_q, funct7_q, imm_funct_q;
  logic [5:0]            funct3_q;
  logic [4:0]            imm5_q;
  logic [DATA_WIDTH-1:0] bus1_q, bus2_q;
  logic                  dov_q;
  logic [TAG_WIDTH-1:0]  issue_tag_q;

  // Free slot and issue candidate both come from start-of-cycle state only.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    sel_found  = 1'b0;
    sel_idx    = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (!valid_q[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IdxW'(i);
      end
      if (valid_q[i] && ent_q[i].src1_rdy && ent_q[i].src2_rdy && !sel_found) begin
        sel_found = 1'b1;
        sel_idx   = IdxW'(i);
      end
    end
  end

  assign disp_ready = (occ_q < OccW'(DEPTH));
  assign disp_fire  = disp_valid && disp_ready && free_found;

  // Dispatch bypass: a same-cycle CDB broadcast satisfies a waiting source directly.
  assign cdb_hit1 = cdb_valid && !disp_src1_rdy && (cdb_tag == disp_src1_tag);
  assign cdb_hit2 = cdb_valid && !disp_src2_rdy && (cdb_tag == disp_src2_tag);

  always_comb begin
    new_ent           = '0;
    new_ent.opcode    = disp_opcode;
    new_ent.funct3    = disp_funct3;
    new_ent.funct7    = disp_funct7;
    new_ent.imm5      = disp_imm5;
    new_ent.imm_funct = disp_imm_funct;
    new_ent.dest_tag  = disp_dest_tag;
    new_ent.src1_rdy  = disp_src1_rdy || cdb_hit1;
    new_ent.src1_val  = cdb_hit1 ? cdb_data : disp_src1_val;
    new_ent.src1_tag  = disp_src1_tag;
    new_ent.src2_rdy  = disp_src2_rdy || cdb_hit2;
    new_ent.src2_val  = cdb_hit2 ? cdb_data : disp_src2_val;
    new_ent.src2_tag  = disp_src2_tag;
  end

  always_comb begin
    valid_d = valid_q;
    ent_d   = ent_q;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (valid_q[i] && cdb_valid) begin
        if (!ent_q[i].src1_rdy && (ent_q[i].src1_tag == cdb_tag)) begin
          ent_d[i].src1_rdy = 1'b1;
          ent_d[i].src1_val = cdb_data;
        end
        if (!ent_q[i].src2_rdy && (ent_q[i].src2_tag == cdb_tag)) begin
          ent_d[i].src2_rdy = 1'b1;
          ent_d[i].src2_val = cdb_data;
        end
      end
    end
    if (sel_found) begin
      valid_d[sel_idx] = 1'b0;
    end
    if (disp_fire) begin
      valid_d[free_idx] = 1'b1;
      ent_d[free_idx]   = new_ent;
    end
    if (flush) begin
      valid_d = '0;
    end
  end

  always_comb begin
    occ_d = occ_q;
    if (flush) begin
      occ_d = '0;
    end else if (disp_fire && !sel_found) begin
      occ_d = occ_q + OccW'(1);
    end else if (!disp_fire && sel_found) begin
      occ_d = occ_q - OccW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= '0;
      occ_q   <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        ent_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      occ_q   <= occ_d;
      for (int i = 0; i < int'(DEPTH); i++) begin
        ent_q[i] <= ent_d[i];
      end
    end
  end

  // Issue register: fields hold their last value when nothing is selected.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      opcode_q    <= '0;
      funct3_q    <= '0;
      funct7_q    <= '0;
      imm5_q      <= '0;
      imm_funct_q <= '0;
      bus1_q      <= '0;
      bus2_q      <= '0;
      issue_tag_q <= '0;
      dov_q       <= 1'b0;
    end else if (flush) begin
      dov_q <= 1'b0;
    end else if (sel_found) begin
      opcode_q    <= ent_q[sel_idx].opcode;
      funct3_q    <= ent_q[sel_idx].funct3;
      funct7_q    <= ent_q[sel_idx].funct7;
      imm5_q      <= ent_q[sel_idx].imm5;
      imm_funct_q <= ent_q[sel_idx].imm_funct;
      bus1_q      <= ent_q[sel_idx].src1_val;
      bus2_q      <= ent_q[sel_idx].src2_val;
      issue_tag_q <= ent_q[sel_idx].dest_tag;
      dov_q       <= 1'b1;
    end else begin
      dov_q <= 1'b0;
    end
  end

  assign opcode         = opcode_q;
  assign funct3         = funct3_q;
  assign funct7         = funct7_q;
  assign reduced_Imm    = imm5_q;
  assign Imm_funct      = imm_funct_q;
  assign BusWires1      = bus1_q;
  assign BusWires2      = bus2_q;
  assign data_out_valid = dov_q;
  assign issue_tag      = issue_tag_q;
  assign occupancy      = occ_q;

endmodule

// File: tb/tb_alu_rs.sv
// Bench for alu_rs: directed scenarios with constant expectations plus a randomized run
// checked against an entry-list reference model.
module tb_alu_rs;

  logic        clk, resetn, flush;
  logic        disp_valid, disp_ready;
  logic [6:0]  disp_opcode, disp_funct7, disp_imm_funct;
  logic [5:0]  disp_funct3;
  logic [4:0]  disp_imm5;
  logic [3:0]  disp_dest_tag, disp_src1_tag, disp_src2_tag;
  logic        disp_src1_rdy, disp_src2_rdy;
  logic [31:0] disp_src1_val, disp_src2_val;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic [6:0]  opcode, funct7, Imm_funct;
  logic [5:0]  funct3;
  logic [4:0]  reduced_Imm;
  logic [31:0] BusWires1, BusWires2;
  logic        data_out_valid;
  logic [3:0]  issue_tag;
  logic [2:0]  occupancy;

  int checks = 0;
  int failures = 0;

  alu_rs #(.DATA_WIDTH(32), .DEPTH(4), .TAG_WIDTH(4)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_opcode(disp_opcode), .disp_funct3(disp_funct3), .disp_funct7(disp_funct7),
    .disp_imm5(disp_imm5), .disp_imm_funct(disp_imm_funct), .disp_dest_tag(disp_dest_tag),
    .disp_src1_rdy(disp_src1_rdy), .disp_src2_rdy(disp_src2_rdy),
    .disp_src1_val(disp_src1_val), .disp_src2_val(disp_src2_val),
    .disp_src1_tag(disp_src1_tag), .disp_src2_tag(disp_src2_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .opcode(opcode), .funct3(funct3), .funct7(funct7), .reduced_Imm(reduced_Imm),
    .Imm_funct(Imm_funct), .BusWires1(BusWires1), .BusWires2(BusWires2),
    .data_out_valid(data_out_valid), .issue_tag(issue_tag), .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a list of slots, each holding one waiting instruction.
  typedef struct packed {
    logic        vld;
    logic [6:0]  op;
    logic [5:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  imm;
    logic [6:0]  immf;
    logic [3:0]  dest;
    logic        r1;
    logic [31:0] v1;
    logic [3:0]  t1;
    logic        r2;
    logic [31:0] v2;
    logic [3:0]  t2;
  } m_ent_t;

  m_ent_t      m_rs [4];
  logic        e_dov;
  logic [6:0]  e_op, e_f7, e_immf;
  logic [5:0]  e_f3;
  logic [4:0]  e_imm;
  logic [3:0]  e_tag;
  logic [31:0] e_bw1, e_bw2;

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < 4; i++) c += int'(m_rs[i].vld);
    return c;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_rs[i] = '0;
    e_dov = 0; e_op = 0; e_f3 = 0; e_f7 = 0; e_imm = 0; e_immf = 0;
    e_tag = 0; e_bw1 = 0; e_bw2 = 0;
  endtask

  task automatic model_step();
    int sel = -1;
    int fr = -1;
    int cnt = m_count();
    m_ent_t n;
    if (flush) begin
      for (int i = 0; i < 4; i++) m_rs[i].vld = 1'b0;
      e_dov = 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sel < 0 && m_rs[i].vld && m_rs[i].r1 && m_rs[i].r2) sel = i;
        if (fr < 0 && !m_rs[i].vld) fr = i;
      end
      e_dov = (sel >= 0);
      if (sel >= 0) begin
        e_op = m_rs[sel].op; e_f3 = m_rs[sel].f3; e_f7 = m_rs[sel].f7;
        e_imm = m_rs[sel].imm; e_immf = m_rs[sel].immf; e_tag = m_rs[sel].dest;
        e_bw1 = m_rs[sel].v1; e_bw2 = m_rs[sel].v2;
        m_rs[sel].vld = 1'b0;
      end
      for (int i = 0; i < 4; i++) begin
        if (m_rs[i].vld && cdb_valid) begin
          if (!m_rs[i].r1 && m_rs[i].t1 == cdb_tag) begin m_rs[i].r1 = 1; m_rs[i].v1 = cdb_data; end
          if (!m_rs[i].r2 && m_rs[i].t2 == cdb_tag) begin m_rs[i].r2 = 1; m_rs[i].v2 = cdb_data; end
        end
      end
      if (disp_valid && cnt < 4) begin
        n = '0;
        n.vld = 1; n.op = disp_opcode; n.f3 = disp_funct3; n.f7 = disp_funct7;
        n.imm = disp_imm5; n.immf = disp_imm_funct; n.dest = disp_dest_tag;
        n.t1 = disp_src1_tag; n.t2 = disp_src2_tag;
        n.r1 = disp_src1_rdy; n.v1 = disp_src1_val;
        n.r2 = disp_src2_rdy; n.v2 = disp_src2_val;
        if (!n.r1 && cdb_valid && cdb_tag == n.t1) begin n.r1 = 1; n.v1 = cdb_data; end
        if (!n.r2 && cdb_valid && cdb_tag == n.t2) begin n.r2 = 1; n.v2 = cdb_data; end
        m_rs[fr] = n;
      end
    end
  endtask

  task automatic tick();
    if (resetn) model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    flush = 0; disp_valid = 0; disp_opcode = 0; disp_funct3 = 0; disp_funct7 = 0;
    disp_imm5 = 0; disp_imm_funct = 0; disp_dest_tag = 0;
    disp_src1_rdy = 0; disp_src2_rdy = 0; disp_src1_val = 0; disp_src2_val = 0;
    disp_src1_tag = 0; disp_src2_tag = 0;
    cdb_valid = 0; cdb_tag = 0; cdb_data = 0;
  endtask

  task automatic drive_disp(input logic [3:0] dest, input logic r1, input logic [31:0] v1,
                            input logic [3:0] t1, input logic r2, input logic [31:0] v2,
                            input logic [3:0] t2);
    disp_valid = 1; disp_opcode = 7'b0110011; disp_funct3 = 6'd0; disp_funct7 = 7'd0;
    disp_imm5 = 5'd0; disp_imm_funct = 7'd0; disp_dest_tag = dest;
    disp_src1_rdy = r1; disp_src1_val = v1; disp_src1_tag = t1;
    disp_src2_rdy = r2; disp_src2_val = v2; disp_src2_tag = t2;
  endtask

  task automatic test_reset();
    clear_in();
    resetn = 1;
    #2 resetn = 0;
    model_reset();
    #1;
    checks++; if (occupancy !== 3'd0) begin failures++; $display("FAIL reset_occ got=%0d exp=0", occupancy); end
    checks++; if (disp_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0b exp=1", disp_ready); end
    checks++; if (data_out_valid !== 1'b0) begin failures++; $display("FAIL reset_dov got=%0b exp=0", data_out_valid); end
    checks++; if (BusWires1 !== 32'd0) begin failures++; $display("FAIL reset_bw1 got=%h exp=0", BusWires1); end
    checks++; if (issue_tag !== 4'd0) begin failures++; $display("FAIL reset_tag got=%h exp=0", issue_tag); end
    @(negedge clk);
    resetn = 1;
  endtask

  task automatic test_add();
    clear_in();
    drive_disp(4'hA, 1, 32'd5, 4'd0, 1, 32'd7, 4'd0);
    tick();
    clear_in();
    checks++; if (data_out_valid !== 1'b0) begin failures++; $display("FAIL add_early got=%0b exp=0", data_out_valid); end
    checks++; if (occupancy !== 3'd1) begin failures++; $display("FAIL add_occ1 got=%0d exp=1", occupancy); end
    tick();
    checks++; if (data_out_valid !== 1'b1) begin failures++; $display("FAIL add_dov got=%0b exp=1", data_out_valid); end
    checks++; if (BusWires1 !== 32'd5) begin failures++; $display("FAIL add_bw1 got=%h exp=5", BusWires1); end
    checks++; if (BusWires2 !== 32'd7) begin failures++; $display("FAIL add_bw2 got=%h exp=7", BusWires2); end
    checks++; if (issue_tag !== 4'hA) begin failures++; $display("FAIL add_tag got=%h exp=a", issue_tag); end
    checks++; if (opcode !== 7'b0110011) begin failures++; $display("FAIL add_op got=%b exp=0110011", opcode); end
    checks++; if (occupancy !== 3'd0) begin failures++; $display("FAIL add_occ0 got=%0d exp=0", occupancy); end
    tick();
    checks++; if (data_out_valid !== 1'b0) begin failures++; $display("FAIL add_pulse got=%0b exp=0", data_out_valid); end
  endtask

  task automatic test_wakeup();
    clear_in();
    drive_disp(4'd2, 0, 32'd0, 4'd3, 1, 32'd1, 4'd0);
    tick();
    clear_in();
    tick();
    checks++; if (data_out_valid !== 1'b0) begin failures++; $display("FAIL wake_wait got=%0b exp=0", data_out_valid); end
    cdb_valid = 1; cdb_tag = 4'd3; cdb_data = 32'h10;
    tick();
    clear_in();
    checks++; if (data_out_valid !== 1'b0) begin failures++; $display("FAIL wake_edge got=%0b exp=0", data_out_valid); end
    tick();
    checks++; if (data_out_valid !== 1'b1) begin failures++; $display("FAIL wake_dov got=%0b exp=1", data_out_valid); end
    checks++; if (BusWires1 !== 32'h10) begin failures++; $display("FAIL wake_bw1 got=%h exp=10", BusWires1); end
    checks++; if (issue_tag !== 4'd2) begin failures++; $display("FAIL wake_tag got=%h exp=2", issue_tag); end
    tick();
  endtask

  task automatic test_bypass();
    clear_in();
    drive_disp(4'd5, 1, 32'd1, 4'd0, 0, 32'd0, 4'd9);
    cdb_valid = 1; cdb_tag = 4'd9; cdb_data = 32'hAB;
    tick();
    clear_in();
    tick();
    checks++; if (data_out_valid !== 1'b1) begin failures++; $display("FAIL byp_dov got=%0b exp=1", data_out_valid); end
    checks++; if (BusWires2 !== 32'hAB) begin failures++; $display("FAIL byp_bw2 got=%h exp=ab", BusWires2); end
    tick();
  endtask

  task automatic test_full_and_flush();
    clear_in();
    for (int k = 0; k < 4; k++) begin
      drive_disp(4'(k), 0, 32'd0, 4'(10 + k), 1, 32'd0, 4'd0);
      tick();
    end
    clear_in();
    checks++; if (disp_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%0b exp=0", disp_ready); end
    checks++; if (occupancy !== 3'd4) begin failures++; $display("FAIL full_occ got=%0d exp=4", occupancy); end
    drive_disp(4'd7, 1, 32'd1, 4'd0, 1, 32'd2, 4'd0);
    tick();
    clear_in();
    checks++; if (occupancy !== 3'd4) begin failures++; $display("FAIL full_drop got=%0d exp=4", occupancy); end
    cdb_valid = 1; cdb_tag = 4'd12; cdb_data = 32'h22;
    tick();
    clear_in();
    checks++; if (data_out_valid !== 1'b0) begin failures++; $display("FAIL full_nodov got=%0b exp=0", data_out_valid); end
    tick();
    checks++; if (issue_tag !== 4'd2 || data_out_valid !== 1'b1) begin failures++; $display("FAIL full_first got=%h/%0b exp=2/1", issue_tag, data_out_valid); end
    checks++; if (disp_ready !== 1'b1) begin failures++; $display("FAIL full_reready got=%0b exp=1", disp_ready); end
    drive_disp(4'd6, 1, 32'h66, 4'd0, 1, 32'h77, 4'd0);
    cdb_valid = 1; cdb_tag = 4'd13; cdb_data = 32'h33;
    tick();
    clear_in();
    checks++; if (occupancy !== 3'd4) begin failures++; $display("FAIL full_refill got=%0d exp=4", occupancy); end
    tick();
    checks++; if (issue_tag !== 4'd6 || BusWires1 !== 32'h66) begin failures++; $display("FAIL full_slot2 got=%h/%h exp=6/66", issue_tag, BusWires1); end
    tick();
    checks++; if (issue_tag !== 4'd3 || data_out_valid !== 1'b1) begin failures++; $display("FAIL full_slot3 got=%h/%0b exp=3/1", issue_tag, data_out_valid); end
    // Entries 0 and 1 still wait; add a third, then flush alongside a dispatch.
    drive_disp(4'd8, 0, 32'd0, 4'd15, 1, 32'd0, 4'd0);
    tick();
    drive_disp(4'd9, 1, 32'd1, 4'd0, 1, 32'd1, 4'd0);
    flush = 1;
    checks++; if (occupancy !== 3'd3) begin failures++; $display("FAIL flush_pre got=%0d exp=3", occupancy); end
    tick();
    clear_in();
    checks++; if (occupancy !== 3'd0) begin failures++; $display("FAIL flush_occ got=%0d exp=0", occupancy); end
    tick();
    checks++; if (data_out_valid !== 1'b0) begin failures++; $display("FAIL flush_dov got=%0b exp=0", data_out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_tag [3];
    exp_tag[0] = 4'd8; exp_tag[1] = 4'd9; exp_tag[2] = 4'd11;
    clear_in();
    for (int k = 0; k < 4; k++) begin
      drive_disp(4'(8 + k), 0, 32'd0, (k == 2) ? 4'd6 : 4'd5, 1, 32'(k), 4'd0);
      tick();
    end
    clear_in();
    cdb_valid = 1; cdb_tag = 4'd5; cdb_data = 32'h55;
    tick();
    clear_in();
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (data_out_valid !== 1'b1 || issue_tag !== exp_tag[k] || BusWires1 !== 32'h55) begin
        failures++;
        $display("FAIL b2b_%0d got=%0b/%h/%h exp=1/%h/55", k, data_out_valid, issue_tag, BusWires1, exp_tag[k]);
      end
    end
    tick();
    checks++; if (data_out_valid !== 1'b0 || occupancy !== 3'd1) begin failures++; $display("FAIL b2b_end got=%0b/%0d exp=0/1", data_out_valid, occupancy); end
    flush = 1;
    tick();
    clear_in();
  endtask

  task automatic test_async_reset();
    clear_in();
    drive_disp(4'd4, 1, 32'd3, 4'd0, 1, 32'd4, 4'd0);
    tick();
    clear_in();
    tick();
    checks++; if (data_out_valid !== 1'b1) begin failures++; $display("FAIL arst_pre got=%0b exp=1", data_out_valid); end
    #2 resetn = 0;
    model_reset();
    #1;
    checks++; if (data_out_valid !== 1'b0 || occupancy !== 3'd0) begin failures++; $display("FAIL arst_drop got=%0b/%0d exp=0/0", data_out_valid, occupancy); end
    #2 resetn = 1;
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      flush = ($urandom_range(0, 31) == 0);
      disp_valid = $urandom_range(0, 1);
      disp_opcode = 7'($urandom); disp_funct3 = 6'($urandom); disp_funct7 = 7'($urandom);
      disp_imm5 = 5'($urandom); disp_imm_funct = 7'($urandom); disp_dest_tag = 4'($urandom);
      disp_src1_rdy = ($urandom_range(0, 2) == 0); disp_src2_rdy = ($urandom_range(0, 2) == 0);
      disp_src1_val = $urandom; disp_src2_val = $urandom;
      disp_src1_tag = 4'($urandom); disp_src2_tag = 4'($urandom);
      cdb_valid = $urandom_range(0, 1); cdb_tag = 4'($urandom); cdb_data = $urandom;
      checks++;
      if (disp_ready !== (m_count() < 4)) begin
        failures++; $display("FAIL rnd_ready c=%0d got=%0b exp=%0b", c, disp_ready, m_count() < 4);
      end
      tick();
      checks++;
      if (data_out_valid !== e_dov || occupancy !== 3'(m_count())) begin
        failures++;
        $display("FAIL rnd_ctl c=%0d got dov=%0b occ=%0d exp dov=%0b occ=%0d", c, data_out_valid,
                 occupancy, e_dov, m_count());
      end
      checks++;
      if (issue_tag !== e_tag || BusWires1 !== e_bw1 || BusWires2 !== e_bw2 || opcode !== e_op ||
          funct3 !== e_f3 || funct7 !== e_f7 || reduced_Imm !== e_imm || Imm_funct !== e_immf) begin
        failures++;
        $display("FAIL rnd_issue c=%0d got tag=%h a=%h b=%h op=%h exp tag=%h a=%h b=%h op=%h", c,
                 issue_tag, BusWires1, BusWires2, opcode, e_tag, e_bw1, e_bw2, e_op);
      end
    end
    clear_in();
  endtask

  initial begin
    test_reset();
    test_add();
    test_wakeup();
    test_bypass();
    test_full_and_flush();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
